// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - default geometry (word-address width, largest legal image)
//   - byte order used when packing stream bytes into 32-bit words
//   - FSM state encoding and the per-state handshake/status flags
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int MAX_WORDS_DEF = 1024;

  // Instructions arrive big-endian: the first byte of a word lands in [31:24].
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic hold;
  } flags_t;

  // Status outputs that depend only on the state being entered. ERR keeps
  // the CPU held so a corrupt image can never start executing.
  function automatic flags_t stateFlags(input state_t s);
    flags_t f;
    f = '0;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: f = '{ready: 1'b1, busy: 1'b1, hold: 1'b1};
      S_WRITE:                             f = '{ready: 1'b0, busy: 1'b1, hold: 1'b1};
      S_ERR:                               f = '{ready: 1'b0, busy: 1'b0, hold: 1'b1};
      default:                             f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_word_packer
// Collects stream bytes into 32-bit instruction words.
// Ports:
//   i_clk, i_reset_n  clock and synchronous active-low reset
//   i_shift_en        accept i_byte into the word this cycle
//   i_clear           discard any partial word (start of a new load)
//   i_byte            stream byte
//   o_word            word formed by the three held bytes plus i_byte
//   o_last_byte       the byte being shifted now completes a word
// ---------------------------------------------------------------------------
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_shift_en,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last_byte
);

  logic [23:0] r_shift;
  logic [1:0]  r_byteCnt;

  // Only three bytes need storing: the fourth is taken straight from the
  // input on the cycle the word completes, so the top can register it
  // into the memory write port on that same edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      r_shift   <= '0;
      r_byteCnt <= '0;
    end else if (i_shift_en) begin
      if (MSB_FIRST) r_shift <= {r_shift[15:0], i_byte};
      else           r_shift <= {i_byte, r_shift[23:8]};
      r_byteCnt <= r_byteCnt + 2'd1;
    end
  end

  assign o_word      = MSB_FIRST ? {r_shift, i_byte} : {i_byte, r_shift};
  assign o_last_byte = (r_byteCnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the word-addressed instruction memory. Receives a
// 16-bit word count (MSB first), count x 4 big-endian instruction bytes and
// a 1-byte XOR checksum of the instruction bytes, writes the words from
// address 0 upward and holds the CPU until the image has been verified.
// Ports:
//   i_clk, i_reset_n   clock and synchronous active-low reset
//   i_start            one-cycle pulse; starts a load from IDLE, DONE or ERR
//   i_byte_in          stream byte, consumed when i_byte_valid && o_byte_ready
//   i_byte_valid       stream byte is valid
//   o_byte_ready       loader accepts a byte this cycle
//   o_mem_addr         word address of the write
//   o_mem_din          word to write
//   o_mem_we           write strobe, one cycle per word
//   o_cpu_hold         holds the PC/pipeline while high
//   o_busy             a load is in progress
//   o_done             last load finished with a good checksum
//   o_error            last load failed on length or checksum
//   o_words_loaded     words written by the current or last load
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_din,
  output logic              o_mem_we,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [15:0]       o_words_loaded
);

  localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

  state_t      r_state;
  state_t      w_nextState;
  flags_t      w_nextFlags;
  logic [7:0]  r_countHi;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic [7:0]  r_checksum;

  logic        w_accept;
  logic        w_startOk;
  logic        w_shiftEn;
  logic [15:0] w_len;
  logic [15:0] w_indexInc;
  logic [31:0] w_word;
  logic        w_lastByte;

  assign w_accept    = i_byte_valid && o_byte_ready;
  assign w_startOk   = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_shiftEn   = w_accept && (r_state == S_DATA);
  assign w_len       = {r_countHi, i_byte_in};
  assign w_indexInc  = r_index + 16'd1;
  assign w_nextFlags = stateFlags(w_nextState);

  imem_loader_word_packer u_packer (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_shift_en  (w_shiftEn),
    .i_clear     (w_startOk),
    .i_byte      (i_byte_in),
    .o_word      (w_word),
    .o_last_byte (w_lastByte)
  );

  // Next-state decode. The outputs are registered from the state being
  // entered, so they line up with r_state without any extra cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_nextState = S_LEN_HI;
      S_LEN_HI:              if (w_accept) w_nextState = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len > MAX_COUNT)  w_nextState = S_ERR;
          else if (w_len == 16'd0) w_nextState = S_CHECK;
          else                     w_nextState = S_DATA;
        end
      end
      S_DATA:  if (w_accept && w_lastByte) w_nextState = S_WRITE;
      S_WRITE: w_nextState = (w_indexInc == r_count) ? S_CHECK : S_DATA;
      S_CHECK: if (w_accept) w_nextState = (i_byte_in == r_checksum) ? S_DONE : S_ERR;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State, datapath registers and all outputs. The write address and data
  // are captured on the edge that completes a word and then held, so they
  // stay stable while the strobe is low.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_countHi      <= '0;
      r_count        <= '0;
      r_index        <= '0;
      r_checksum     <= '0;
      o_byte_ready   <= 1'b0;
      o_busy         <= 1'b0;
      o_cpu_hold     <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_mem_we       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_din      <= '0;
      o_words_loaded <= '0;
    end else begin
      r_state      <= w_nextState;
      o_byte_ready <= w_nextFlags.ready;
      o_busy       <= w_nextFlags.busy;
      o_cpu_hold   <= w_nextFlags.hold;
      o_done       <= (w_nextState == S_DONE);
      o_error      <= (w_nextState == S_ERR);
      o_mem_we     <= (w_nextState == S_WRITE);
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_index        <= '0;
            r_checksum     <= '0;
            o_words_loaded <= '0;
          end
        end
        S_LEN_HI: if (w_accept) r_countHi <= i_byte_in;
        S_LEN_LO: if (w_accept) r_count <= w_len;
        S_DATA: begin
          if (w_accept) begin
            r_checksum <= r_checksum ^ i_byte_in;
            if (w_lastByte) begin
              o_mem_addr <= r_index[ADDR_W-1:0];
              o_mem_din  <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_index        <= w_indexInc;
          o_words_loaded <= o_words_loaded + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for the instruction-memory loader. A stream-level model
// follows the byte stream (header, data words, checksum) and predicts every
// output each cycle; literal expectations pin the model on known images.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_start = 1'b0;
  logic [7:0]        i_byte_in = 8'h00;
  logic              i_byte_valid = 1'b0;
  logic              o_byte_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_din;
  logic              o_mem_we;
  logic              o_cpu_hold;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [15:0]       o_words_loaded;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_start        (i_start),
    .i_byte_in      (i_byte_in),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_mem_addr     (o_mem_addr),
    .o_mem_din      (o_mem_din),
    .o_mem_we       (o_mem_we),
    .o_cpu_hold     (o_cpu_hold),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_loaded (o_words_loaded)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream-level model state: whether a load is running, how far through
  // the stream it is, and the outputs expected in the current cycle.
  logic        m_active = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic        m_ready = 1'b0, m_we = 1'b0, m_nWe;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_din = '0, m_word = '0;
  logic [15:0] m_wl = '0;
  logic [7:0]  m_chk = '0, m_b;
  int          m_pos = 0, m_cnt = 0;
  bit          seenReset = 1'b0;
  int          weSeen = 0;
  logic [31:0] tbMem [0:MAX_WORDS-1];

  // Compare, then advance the model by whatever the next edge will see.
  always @(negedge clk) begin
    if (seenReset) begin
      checkOutput("byte_ready", 32'(o_byte_ready), 32'(m_ready));
      checkOutput("busy", 32'(o_busy), 32'(m_active));
      checkOutput("cpu_hold", 32'(o_cpu_hold), 32'(m_active || m_err));
      checkOutput("done", 32'(o_done), 32'(m_done));
      checkOutput("error", 32'(o_error), 32'(m_err));
      checkOutput("mem_we", 32'(o_mem_we), 32'(m_we));
      checkOutput("mem_addr", 32'(o_mem_addr), 32'(m_addr));
      checkOutput("mem_din", o_mem_din, m_din);
      checkOutput("words_loaded", 32'(o_words_loaded), 32'(m_wl));
    end
    if (o_mem_we === 1'b1) begin
      tbMem[o_mem_addr] = o_mem_din;
      weSeen++;
    end
    m_nWe = 1'b0;
    if (!i_reset_n) begin
      seenReset = 1'b1;
      m_active = 0; m_done = 0; m_err = 0; m_ready = 0; m_we = 0;
      m_addr = '0; m_din = '0; m_wl = '0; m_pos = 0; m_chk = '0; m_word = '0;
    end else begin
      if (m_we) m_wl = m_wl + 16'd1;
      if (i_start && !m_active) begin
        m_active = 1; m_done = 0; m_err = 0; m_wl = '0; m_pos = 0; m_chk = '0;
      end else if (i_byte_valid && m_ready) begin
        m_b = i_byte_in;
        if (m_pos == 0) begin
          m_cnt = int'(m_b) * 256;
        end else if (m_pos == 1) begin
          m_cnt = m_cnt + int'(m_b);
          if (m_cnt > MAX_WORDS) begin m_active = 0; m_err = 1; end
        end else if (m_pos < 2 + 4 * m_cnt) begin
          m_word = {m_word[23:0], m_b};
          m_chk  = m_chk ^ m_b;
          if ((m_pos - 2) % 4 == 3) begin
            m_nWe  = 1'b1;
            m_addr = 10'((m_pos - 2) / 4);
            m_din  = m_word;
          end
        end else begin
          m_active = 0;
          if (m_b == m_chk) m_done = 1; else m_err = 1;
        end
        m_pos++;
      end
      m_we    = m_nWe;
      m_ready = m_active && !m_nWe;
    end
  end

  logic [7:0] img[$];

  task automatic makeImage(input logic [15:0] cnt, input logic [31:0] w0, input logic [31:0] w1,
                           input int nWords, input logic [7:0] chk);
    logic [31:0] w;
    img.delete();
    img.push_back(cnt[15:8]);
    img.push_back(cnt[7:0]);
    for (int i = 0; i < nWords; i++) begin
      w = (i == 0) ? w0 : w1;
      img.push_back(w[31:24]); img.push_back(w[23:16]);
      img.push_back(w[15:8]);  img.push_back(w[7:0]);
    end
    img.push_back(chk);
  endtask

  // Offer img[first..last] with the given valid duty (percent). Called and
  // returns just after a rising edge.
  task automatic applyStimulus(input int first, input int last, input int duty);
    int idx = first;
    int cyc = 0;
    bit take;
    while (idx <= last && cyc < 400) begin
      i_byte_in    = img[idx];
      i_byte_valid = (duty >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < duty);
      @(negedge clk);
      take = i_byte_valid && o_byte_ready;
      @(posedge clk); #1;
      if (take) idx++;
      cyc++;
    end
    i_byte_valid = 1'b0;
    if (idx <= last) checkOutput("stream_timeout", 32'(idx), 32'(last + 1));
  endtask

  task automatic pulseStart();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_hold", 32'(o_cpu_hold), 32'd0);
    checkOutput("reset_ready", 32'(o_byte_ready), 32'd0);

    $display("[TB] normal load");
    makeImage(16'd2, 32'h11223344, 32'hAABBCCDD, 2, 8'h44);
    base = weSeen;
    pulseStart();
    applyStimulus(0, 10, 100);
    settle();
    checkOutput("model_checksum_pin", 32'(m_chk), 32'h44);
    checkOutput("normal_mem0", tbMem[0], 32'h11223344);
    checkOutput("normal_mem1", tbMem[1], 32'hAABBCCDD);
    checkOutput("normal_writes", 32'(weSeen - base), 32'd2);
    checkOutput("normal_done", 32'(o_done), 32'd1);
    checkOutput("normal_hold", 32'(o_cpu_hold), 32'd0);
    checkOutput("normal_wl", 32'(o_words_loaded), 32'd2);

    $display("[TB] bad checksum");
    makeImage(16'd2, 32'h11223344, 32'hAABBCCDD, 2, 8'h01);
    base = weSeen;
    pulseStart();
    applyStimulus(0, 10, 100);
    settle();
    checkOutput("badchk_writes", 32'(weSeen - base), 32'd2);
    checkOutput("badchk_error", 32'(o_error), 32'd1);
    checkOutput("badchk_done", 32'(o_done), 32'd0);
    checkOutput("badchk_hold", 32'(o_cpu_hold), 32'd1);

    $display("[TB] oversized count");
    makeImage(16'h0401, 32'h0, 32'h0, 0, 8'h00);
    base = weSeen;
    pulseStart();
    applyStimulus(0, 1, 100);
    settle();
    checkOutput("len_error", 32'(o_error), 32'd1);
    checkOutput("len_busy", 32'(o_busy), 32'd0);
    checkOutput("len_writes", 32'(weSeen - base), 32'd0);

    $display("[TB] gapped stream");
    makeImage(16'd2, 32'h11223344, 32'hAABBCCDD, 2, 8'h44);
    tbMem[0] = '0; tbMem[1] = '0;
    base = weSeen;
    pulseStart();
    applyStimulus(0, 10, 30);
    settle();
    checkOutput("gap_mem0", tbMem[0], 32'h11223344);
    checkOutput("gap_mem1", tbMem[1], 32'hAABBCCDD);
    checkOutput("gap_writes", 32'(weSeen - base), 32'd2);
    checkOutput("gap_done", 32'(o_done), 32'd1);

    $display("[TB] reload after done, empty image");
    pulseStart();
    checkOutput("reload_done", 32'(o_done), 32'd0);
    checkOutput("reload_wl", 32'(o_words_loaded), 32'd0);
    checkOutput("reload_hold", 32'(o_cpu_hold), 32'd1);
    makeImage(16'd0, 32'h0, 32'h0, 0, 8'h00);
    base = weSeen;
    applyStimulus(0, 2, 100);
    settle();
    checkOutput("empty_done", 32'(o_done), 32'd1);
    checkOutput("empty_writes", 32'(weSeen - base), 32'd0);

    $display("[TB] reset mid-load");
    makeImage(16'd2, 32'h11223344, 32'hAABBCCDD, 2, 8'h44);
    pulseStart();
    applyStimulus(0, 7, 100);
    i_reset_n = 1'b0;
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_hold", 32'(o_cpu_hold), 32'd0);
    checkOutput("midrst_done", 32'(o_done), 32'd0);
    checkOutput("midrst_addr", 32'(o_mem_addr), 32'd0);
    checkOutput("midrst_din", o_mem_din, 32'd0);
    checkOutput("midrst_wl", 32'(o_words_loaded), 32'd0);
    tbMem[0] = '0; tbMem[1] = '0;
    pulseStart();
    applyStimulus(0, 10, 100);
    settle();
    checkOutput("afterrst_mem0", tbMem[0], 32'h11223344);
    checkOutput("afterrst_mem1", tbMem[1], 32'hAABBCCDD);
    checkOutput("afterrst_done", 32'(o_done), 32'd1);

    $display("[TB] start while busy");
    base = weSeen;
    pulseStart();
    applyStimulus(0, 3, 100);
    pulseStart();
    applyStimulus(4, 10, 100);
    settle();
    checkOutput("busystart_writes", 32'(weSeen - base), 32'd2);
    checkOutput("busystart_wl", 32'(o_words_loaded), 32'd2);
    checkOutput("busystart_done", 32'(o_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
